// File: rtl/vp8_quant_pkg.sv
// Shared constants and types for the VP8 4x4 quantizer: zigzag scan order,
// fixed-point defaults and the job FSM state.
package vp8_quant_pkg;

    localparam int QFIX_DEF      = 17;
    localparam int MAX_LEVEL_DEF = 2047;

    // Raster index j for each zigzag position n.
    localparam logic [3:0] ZIGZAG [16] = '{
        4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/vp8_quant_lane.sv
// Combinational quantize/dequantize of a single coefficient:
// level = sign(c) * min(((|c| + sharpen) * iq + bias) >> QFIX, MAX_LEVEL), dq = sat(level * q).
module vp8_quant_lane #(
    parameter int SRC_WIDTH  = 16,
    parameter int LVL_WIDTH  = 12,
    parameter int Q_WIDTH    = 12,
    parameter int IQ_WIDTH   = 18,
    parameter int BIAS_WIDTH = 18,
    parameter int QFIX       = 17,
    parameter int MAX_LEVEL  = 2047
) (
    input  logic signed [SRC_WIDTH-1:0]  c_i,
    input  logic        [7:0]            sharpen_i,
    input  logic        [Q_WIDTH-1:0]    q_i,
    input  logic        [IQ_WIDTH-1:0]   iq_i,
    input  logic        [BIAS_WIDTH-1:0] bias_i,
    input  logic        [IQ_WIDTH-1:0]   zthr_i,
    input  logic                         bypass_i,
    output logic signed [LVL_WIDTH-1:0]  level_o,
    output logic signed [SRC_WIDTH-1:0]  dq_o
);

    // One extra magnitude bit so |-2^(SRC_WIDTH-1)| is representable.
    localparam int AW = SRC_WIDTH + 1;
    localparam int PW = AW + IQ_WIDTH + 1;
    localparam int DW = LVL_WIDTH + Q_WIDTH + 1;

    logic        [AW-1:0]        mag;
    logic        [AW-1:0]        a;
    logic        [PW-1:0]        acc;
    logic        [PW-1:0]        shifted;
    logic        [LVL_WIDTH-1:0] lmag;
    logic signed [LVL_WIDTH-1:0] lvl;
    logic signed [DW-1:0]        prod;
    logic signed [DW-1:0]        dq_max;
    logic signed [DW-1:0]        dq_min;

    always_comb begin
        mag     = c_i[SRC_WIDTH-1] ? AW'(-{c_i[SRC_WIDTH-1], c_i}) : AW'({c_i[SRC_WIDTH-1], c_i});
        a       = mag + AW'(sharpen_i);
        acc     = PW'(a) * PW'(iq_i) + PW'(bias_i);
        shifted = acc >> QFIX;

        if (PW'(a) > PW'(zthr_i)) begin
            lmag = (shifted > PW'(MAX_LEVEL)) ? LVL_WIDTH'(MAX_LEVEL) : shifted[LVL_WIDTH-1:0];
        end else begin
            lmag = '0;
        end
        lvl = c_i[SRC_WIDTH-1] ? -$signed(lmag) : $signed(lmag);

        dq_max = {{(DW-SRC_WIDTH+1){1'b0}}, {(SRC_WIDTH-1){1'b1}}};
        dq_min = {{(DW-SRC_WIDTH+1){1'b1}}, {(SRC_WIDTH-1){1'b0}}};
        prod   = DW'(lvl) * DW'($signed({1'b0, q_i}));

        if (bypass_i) begin
            level_o = '0;
            dq_o    = c_i;
        end else begin
            level_o = lvl;
            if (prod > dq_max) begin
                dq_o = dq_max[SRC_WIDTH-1:0];
            end else if (prod < dq_min) begin
                dq_o = dq_min[SRC_WIDTH-1:0];
            end else begin
                dq_o = prod[SRC_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/vp8_quantize_4x4.sv
// VP8 4x4 block quantizer: 4 coefficients per cycle over 4 RUN cycles, zigzag levels + raster dequant.
// Optional per-coefficient sharpen input enabled by defining VP8_QUANT_SHARPEN_EN.
module vp8_quantize_4x4
    import vp8_quant_pkg::*;
#(
    parameter int SRC_WIDTH  = 16,
    parameter int LVL_WIDTH  = 12,
    parameter int Q_WIDTH    = 12,
    parameter int IQ_WIDTH   = 18,
    parameter int BIAS_WIDTH = 18,
    parameter int QFIX       = QFIX_DEF,
    parameter int MAX_LEVEL  = MAX_LEVEL_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      skip_dc,
    input  logic [16*SRC_WIDTH-1:0]   coeff,
    input  logic [Q_WIDTH-1:0]        q_dc,
    input  logic [Q_WIDTH-1:0]        q_ac,
    input  logic [IQ_WIDTH-1:0]       iq_dc,
    input  logic [IQ_WIDTH-1:0]       iq_ac,
    input  logic [BIAS_WIDTH-1:0]     bias_dc,
    input  logic [BIAS_WIDTH-1:0]     bias_ac,
    input  logic [IQ_WIDTH-1:0]       zthr_dc,
    input  logic [IQ_WIDTH-1:0]       zthr_ac,
`ifdef VP8_QUANT_SHARPEN_EN
    input  logic [16*8-1:0]           sharpen,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [16*LVL_WIDTH-1:0]   level,
    output logic [16*SRC_WIDTH-1:0]   dq,
    output logic [4:0]                last,
    output logic                      nz,
    output state_t                    dbg_state
);

    // Handshake: start is sampled on any edge where busy=0 (including the done cycle);
    // done is a one-cycle pulse and level/dq/last/nz hold until the next job's done.

    state_t                    state_q, state_d;
    logic [1:0]                g_q, g_d;
    logic                      accept;

    logic [16*SRC_WIDTH-1:0]   coeff_q;
    logic                      skip_q;
    logic [Q_WIDTH-1:0]        q_dc_q, q_ac_q;
    logic [IQ_WIDTH-1:0]       iq_dc_q, iq_ac_q, zthr_dc_q, zthr_ac_q;
    logic [BIAS_WIDTH-1:0]     bias_dc_q, bias_ac_q;
    logic [16*8-1:0]           sharpen_v;

    logic signed [LVL_WIDTH-1:0] lvl_w_q [16];
    logic signed [LVL_WIDTH-1:0] lvl_nx  [16];
    logic signed [SRC_WIDTH-1:0] dq_w_q  [16];
    logic signed [SRC_WIDTH-1:0] dq_nx   [16];
    logic [4:0]                  last_nx;

    logic [16*LVL_WIDTH-1:0]   level_q;
    logic [16*SRC_WIDTH-1:0]   dq_q;
    logic [4:0]                last_q;
    logic                      done_q;

    logic [3:0]                  lane_n    [4];
    logic [3:0]                  lane_j    [4];
    logic signed [SRC_WIDTH-1:0] lane_c    [4];
    logic [7:0]                  lane_sh   [4];
    logic [Q_WIDTH-1:0]          lane_q    [4];
    logic [IQ_WIDTH-1:0]         lane_iq   [4];
    logic [BIAS_WIDTH-1:0]       lane_bias [4];
    logic [IQ_WIDTH-1:0]         lane_zthr [4];
    logic                        lane_byp  [4];
    logic signed [LVL_WIDTH-1:0] lane_lvl  [4];
    logic signed [SRC_WIDTH-1:0] lane_dq   [4];

`ifdef VP8_QUANT_SHARPEN_EN
    logic [16*8-1:0] sharpen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sharpen_q <= '0;
        end else if (accept) begin
            sharpen_q <= sharpen;
        end
    end

    assign sharpen_v = sharpen_q;
`else
    assign sharpen_v = '0;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    g_d     = 2'd0;
                end
            end
            RUN: begin
                g_d = g_q + 2'd1;
                if (g_q == 2'd3) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (state_q == RUN);
        done      = done_q;
        level     = level_q;
        dq        = dq_q;
        last      = last_q;
        nz        = ~last_q[4];
        dbg_state = state_q;
    end

    // Group g covers zigzag positions 4g..4g+3; each lane fetches its raster coefficient.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_n[k]  = {g_q, 2'(k)};
            lane_j[k]  = ZIGZAG[lane_n[k]];
            lane_c[k]  = coeff_q[SRC_WIDTH*lane_j[k] +: SRC_WIDTH];
            lane_sh[k] = sharpen_v[8*lane_j[k] +: 8];
            if (lane_j[k] == 4'd0) begin
                lane_q[k]    = q_dc_q;
                lane_iq[k]   = iq_dc_q;
                lane_bias[k] = bias_dc_q;
                lane_zthr[k] = zthr_dc_q;
            end else begin
                lane_q[k]    = q_ac_q;
                lane_iq[k]   = iq_ac_q;
                lane_bias[k] = bias_ac_q;
                lane_zthr[k] = zthr_ac_q;
            end
            lane_byp[k] = skip_q && (lane_j[k] == 4'd0);
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        vp8_quant_lane #(
            .SRC_WIDTH  (SRC_WIDTH),
            .LVL_WIDTH  (LVL_WIDTH),
            .Q_WIDTH    (Q_WIDTH),
            .IQ_WIDTH   (IQ_WIDTH),
            .BIAS_WIDTH (BIAS_WIDTH),
            .QFIX       (QFIX),
            .MAX_LEVEL  (MAX_LEVEL)
        ) u_lane (
            .c_i       (lane_c[k]),
            .sharpen_i (lane_sh[k]),
            .q_i       (lane_q[k]),
            .iq_i      (lane_iq[k]),
            .bias_i    (lane_bias[k]),
            .zthr_i    (lane_zthr[k]),
            .bypass_i  (lane_byp[k]),
            .level_o   (lane_lvl[k]),
            .dq_o      (lane_dq[k])
        );
    end

    // Working set with the current group merged in; last scans the merged set.
    always_comb begin
        lvl_nx = lvl_w_q;
        dq_nx  = dq_w_q;
        for (int k = 0; k < 4; k++) begin
            lvl_nx[lane_n[k]] = lane_lvl[k];
            dq_nx[lane_j[k]]  = lane_dq[k];
        end
        last_nx = 5'h1F;
        for (int n = 0; n < 16; n++) begin
            if (lvl_nx[n] != '0) begin
                last_nx = 5'(n);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coeff_q   <= '0;
            skip_q    <= 1'b0;
            q_dc_q    <= '0;
            q_ac_q    <= '0;
            iq_dc_q   <= '0;
            iq_ac_q   <= '0;
            bias_dc_q <= '0;
            bias_ac_q <= '0;
            zthr_dc_q <= '0;
            zthr_ac_q <= '0;
            for (int n = 0; n < 16; n++) begin
                lvl_w_q[n] <= '0;
                dq_w_q[n]  <= '0;
            end
            level_q <= '0;
            dq_q    <= '0;
            last_q  <= 5'h1F;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                coeff_q   <= coeff;
                skip_q    <= skip_dc;
                q_dc_q    <= q_dc;
                q_ac_q    <= q_ac;
                iq_dc_q   <= iq_dc;
                iq_ac_q   <= iq_ac;
                bias_dc_q <= bias_dc;
                bias_ac_q <= bias_ac;
                zthr_dc_q <= zthr_dc;
                zthr_ac_q <= zthr_ac;
            end
            if (state_q == RUN) begin
                lvl_w_q <= lvl_nx;
                dq_w_q  <= dq_nx;
                if (g_q == 2'd3) begin
                    for (int n = 0; n < 16; n++) begin
                        level_q[LVL_WIDTH*n +: LVL_WIDTH] <= lvl_nx[n];
                        dq_q[SRC_WIDTH*n +: SRC_WIDTH]    <= dq_nx[n];
                    end
                    last_q <= last_nx;
                    done_q <= 1'b1;
                end
            end
        end
    end

endmodule
